// File: rtl/freelist_pkg.sv
// Shared definitions for the physical-register free list.
//   PREG_NUM / AREG_NUM  : physical / architectural register counts
//   MACHINE_WIDTH        : allocation lanes per cycle
//   ISSUE_WIDTH          : release / commit lanes per cycle
//   FL_DEPTH             : free-list capacity (PREG_NUM - AREG_NUM)
//   fl_ptr_t             : {wrap, index} pointer; the wrap bit separates full from empty
//   popcount()           : number of set lanes in a lane mask
package freelist_pkg;
  localparam int PREG_NUM      = 64;
  localparam int AREG_NUM      = 32;
  localparam int MACHINE_WIDTH = 2;
  localparam int ISSUE_WIDTH   = 2;
  localparam int FL_DEPTH      = PREG_NUM - AREG_NUM;
  localparam int PREG_W        = $clog2(PREG_NUM);
  localparam int FL_IDX_W      = $clog2(FL_DEPTH);
  localparam int CNT_W         = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0]   preg_addr_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;
  // MSB is the wrap bit, low FL_IDX_W bits index the RAM.
  typedef logic [FL_IDX_W:0]   fl_ptr_t;
  typedef logic [CNT_W-1:0]    fl_cnt_t;

  // Lane masks are zero-extended to 8 bits by the caller.
  function automatic fl_cnt_t popcount(input logic [7:0] mask);
    fl_cnt_t c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + fl_cnt_t'(mask[i]);
    return c;
  endfunction
endpackage

// File: rtl/freelist_ram.sv
// Free-list tag storage: FL_DEPTH entries of preg tags.
//   rd_idx/rd_data : MACHINE_WIDTH asynchronous read ports
//   wr_en/wr_idx/wr_data : ISSUE_WIDTH write ports, applied at the clock edge
//   mem_o          : full contents, only present with FREELIST_CHECK_EN
// Reset loads entry i with tag AREG_NUM+i.
module freelist_ram
  import freelist_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  fl_idx_t    [MACHINE_WIDTH-1:0]     rd_idx,
  output preg_addr_t [MACHINE_WIDTH-1:0]     rd_data,
  input  logic       [ISSUE_WIDTH-1:0]       wr_en,
  input  fl_idx_t    [ISSUE_WIDTH-1:0]       wr_idx,
  input  preg_addr_t [ISSUE_WIDTH-1:0]       wr_data
`ifdef FREELIST_CHECK_EN
  ,
  output preg_addr_t [FL_DEPTH-1:0]          mem_o
`endif
);
  preg_addr_t [FL_DEPTH-1:0] mem_q, mem_d;

  // Write indices are distinct (consecutive slots from tail), so order is irrelevant.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < ISSUE_WIDTH; j++)
      if (wr_en[j]) mem_d[wr_idx[j]] = wr_data[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= preg_addr_t'(AREG_NUM + i);
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) rd_data[i] = mem_q[rd_idx[i]];
  end

`ifdef FREELIST_CHECK_EN
  assign mem_o = mem_q;
`endif
endmodule

// File: rtl/preg_freelist.sv
// Circular free list of physical register tags for renaming.
//   alloc_req/alloc_grant/alloc_preg : zero-latency allocation, all-or-nothing
//   commit_valid                     : advances the committed head
//   release_valid/release_preg       : returns old mappings at the tail
//   flush                            : speculative head <= committed head (+ same-cycle commits)
//   free_count                       : tail - head
//   err                              : sticky consistency error
// Handshake: alloc_req is a per-lane request; alloc_grant is high only when
// every requested lane is served in this cycle, and then (and only then) the
// head advances at the edge. A zero-request cycle reports grant.
// Optional: define FREELIST_CHECK_EN to build the busy vector and drive err;
// otherwise err is tied low.
module preg_freelist
  import freelist_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic       [MACHINE_WIDTH-1:0] alloc_req,
  output logic                           alloc_grant,
  output preg_addr_t [MACHINE_WIDTH-1:0] alloc_preg,
  input  logic       [ISSUE_WIDTH-1:0]   commit_valid,
  input  logic       [ISSUE_WIDTH-1:0]   release_valid,
  input  preg_addr_t [ISSUE_WIDTH-1:0]   release_preg,
  input  logic                           flush,
  output fl_cnt_t                        free_count,
  output logic                           err
);
  fl_ptr_t head_q, head_d, commit_head_q, commit_head_d, tail_q, tail_d;
  fl_cnt_t n_alloc, n_rel, n_com;

  fl_idx_t    [MACHINE_WIDTH-1:0] rd_idx;
  preg_addr_t [MACHINE_WIDTH-1:0] rd_data;
  logic       [ISSUE_WIDTH-1:0]   wr_en;
  fl_idx_t    [ISSUE_WIDTH-1:0]   wr_idx;
`ifdef FREELIST_CHECK_EN
  preg_addr_t [FL_DEPTH-1:0]      mem;
`endif

  freelist_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (release_preg)
`ifdef FREELIST_CHECK_EN
    ,
    .mem_o   (mem)
`endif
  );

  always_comb begin
    int rank;
    n_alloc     = popcount(8'(alloc_req));
    n_rel       = popcount(8'(release_valid));
    n_com       = popcount(8'(commit_valid));
    free_count  = tail_q - head_q;
    alloc_grant = !flush && (free_count >= n_alloc);

    // Read port k always looks at head+k; lanes pick the port matching their rank.
    for (int k = 0; k < MACHINE_WIDTH; k++)
      rd_idx[k] = head_q[FL_IDX_W-1:0] + fl_idx_t'(k);

    rank = 0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      alloc_preg[i] = '0;
      if (alloc_req[i]) begin
        for (int k = 0; k < MACHINE_WIDTH; k++)
          if (alloc_grant && k == rank) alloc_preg[i] = rd_data[k];
        rank = rank + 1;
      end
    end

    // Released tags pack into consecutive slots from tail in lane order.
    rank = 0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      wr_en[j]  = release_valid[j];
      wr_idx[j] = tail_q[FL_IDX_W-1:0] + fl_idx_t'(rank);
      if (release_valid[j]) rank = rank + 1;
    end

    commit_head_d = commit_head_q + n_com;
    tail_d        = tail_q + n_rel;
    if (flush)            head_d = commit_head_d;
    else if (alloc_grant) head_d = head_q + n_alloc;
    else                  head_d = head_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= fl_ptr_t'(FL_DEPTH);
    end else begin
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic [PREG_NUM-1:0] busy_q, busy_d, member;
  logic                err_q, err_d;

  always_comb begin
    fl_ptr_t span;
    fl_idx_t off;
    busy_d = busy_q;
    err_d  = err_q;
    member = '0;
    // Entries still free after this edge, not counting this cycle's releases.
    span   = tail_q - head_d;

    if (alloc_grant)
      for (int i = 0; i < MACHINE_WIDTH; i++)
        if (alloc_req[i]) busy_d[alloc_preg[i]] = 1'b1;

    // Tags are PREG_W bits and PREG_NUM is a power of two, so every tag is in range.
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (release_valid[j]) begin
        if (!busy_q[release_preg[j]]) err_d = 1'b1;
        busy_d[release_preg[j]] = 1'b0;
        member[release_preg[j]] = 1'b1;
      end
    end

    if (flush) begin
      for (int e = 0; e < FL_DEPTH; e++) begin
        off = fl_idx_t'(e) - head_d[FL_IDX_W-1:0];
        if ({1'b0, off} < span) member[mem[e]] = 1'b1;
      end
      busy_d = ~member;
    end

    if ((CNT_W + 1)'(span) + (CNT_W + 1)'(n_rel) > (CNT_W + 1)'(FL_DEPTH)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {{(PREG_NUM - AREG_NUM){1'b0}}, {AREG_NUM{1'b1}}};
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_preg_freelist.sv
module tb_preg_freelist;
  import freelist_pkg::*;

  logic                           clk;
  logic                           reset;
  logic       [MACHINE_WIDTH-1:0] alloc_req;
  logic                           alloc_grant;
  preg_addr_t [MACHINE_WIDTH-1:0] alloc_preg;
  logic       [ISSUE_WIDTH-1:0]   commit_valid;
  logic       [ISSUE_WIDTH-1:0]   release_valid;
  preg_addr_t [ISSUE_WIDTH-1:0]   release_preg;
  logic                           flush;
  fl_cnt_t                        free_count;
  logic                           err;

  int checks;
  int failures;

`ifdef FREELIST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  preg_freelist dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_grant   (alloc_grant),
    .alloc_preg    (alloc_preg),
    .commit_valid  (commit_valid),
    .release_valid (release_valid),
    .release_preg  (release_preg),
    .flush         (flush),
    .free_count    (free_count),
    .err           (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1ns after the rising edge, outputs are
  // sampled 1ns after the inputs settle, well away from the next edge.
  task automatic idle();
    alloc_req     = '0;
    commit_valid  = '0;
    release_valid = '0;
    release_preg  = '0;
    flush         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (free_count !== fl_cnt_t'(32)) begin
      $display("FAIL reset_free_count got=%0d exp=32", free_count); failures++;
    end
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL reset_err got=%0b exp=0", err); failures++;
    end
    checks++;
    if (alloc_grant !== 1'b1) begin
      $display("FAIL reset_zero_req_grant got=%0b exp=1", alloc_grant); failures++;
    end
  endtask

  task automatic test_basic_alloc();
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd33) begin
      $display("FAIL basic_alloc got grant=%0b {%0d,%0d} exp grant=1 {33,32}",
               alloc_grant, alloc_preg[1], alloc_preg[0]); failures++;
    end
    checks++;
    if (free_count !== fl_cnt_t'(32)) begin
      $display("FAIL basic_alloc_count_before got=%0d exp=32", free_count); failures++;
    end
    step();
    checks++;
    if (free_count !== fl_cnt_t'(30)) begin
      $display("FAIL basic_alloc_count_after got=%0d exp=30", free_count); failures++;
    end
  endtask

  // Continues from head=2: 15 more pairs empty the list.
  task automatic test_drain();
    for (int c = 1; c < 16; c++) begin
      alloc_req = 2'b11;
      #1;
      checks++;
      if (alloc_grant !== 1'b1 || alloc_preg[0] !== preg_addr_t'(32 + 2 * c) ||
          alloc_preg[1] !== preg_addr_t'(33 + 2 * c)) begin
        $display("FAIL drain_pair%0d got grant=%0b {%0d,%0d} exp grant=1 {%0d,%0d}",
                 c, alloc_grant, alloc_preg[1], alloc_preg[0], 33 + 2 * c, 32 + 2 * c);
        failures++;
      end
      step();
    end
    checks++;
    if (free_count !== fl_cnt_t'(0)) begin
      $display("FAIL drain_empty_count got=%0d exp=0", free_count); failures++;
    end
    alloc_req = 2'b01;
    #1;
    checks++;
    if (alloc_grant !== 1'b0 || alloc_preg[0] !== 6'd0) begin
      $display("FAIL empty_deny got grant=%0b lane0=%0d exp grant=0 lane0=0",
               alloc_grant, alloc_preg[0]); failures++;
    end
    step();
    checks++;
    if (free_count !== fl_cnt_t'(0)) begin
      $display("FAIL empty_head_hold got=%0d exp=0", free_count); failures++;
    end
    alloc_req = 2'b00;
    #1;
    checks++;
    if (alloc_grant !== 1'b1) begin
      $display("FAIL empty_zero_req_grant got=%0b exp=1", alloc_grant); failures++;
    end
  endtask

  task automatic test_release_from_empty();
    alloc_req       = 2'b11;
    release_valid   = 2'b11;
    release_preg[0] = 6'd5;
    release_preg[1] = 6'd7;
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      $display("FAIL release_same_cycle_deny got=%0b exp=0", alloc_grant); failures++;
    end
    step();
    checks++;
    if (free_count !== fl_cnt_t'(2)) begin
      $display("FAIL release_count got=%0d exp=2", free_count); failures++;
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd5 || alloc_preg[1] !== 6'd7) begin
      $display("FAIL release_realloc got grant=%0b {%0d,%0d} exp grant=1 {7,5}",
               alloc_grant, alloc_preg[1], alloc_preg[0]); failures++;
    end
    step();
    checks++;
    if (free_count !== fl_cnt_t'(0)) begin
      $display("FAIL release_realloc_count got=%0d exp=0", free_count); failures++;
    end
  endtask

  task automatic test_flush_reclaim();
    do_reset();
    alloc_req    = 2'b11;
    commit_valid = 2'b11;
    step();
    alloc_req = 2'b11;
    step();
    alloc_req = 2'b11;
    step();
    checks++;
    if (free_count !== fl_cnt_t'(26)) begin
      $display("FAIL flush_pre_count got=%0d exp=26", free_count); failures++;
    end
    flush     = 1'b1;
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      $display("FAIL flush_no_grant got=%0b exp=0", alloc_grant); failures++;
    end
    step();
    checks++;
    if (free_count !== fl_cnt_t'(30)) begin
      $display("FAIL flush_reclaim_count got=%0d exp=30", free_count); failures++;
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd34 || alloc_preg[1] !== 6'd35) begin
      $display("FAIL flush_realloc got grant=%0b {%0d,%0d} exp grant=1 {35,34}",
               alloc_grant, alloc_preg[1], alloc_preg[0]); failures++;
    end
    step();
  endtask

  // Continues with head=4, commit_head=2, tail=32.
  task automatic test_flush_commit_release();
    flush           = 1'b1;
    alloc_req       = 2'b01;
    commit_valid    = 2'b01;
    release_valid   = 2'b01;
    release_preg[0] = 6'd40;
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      $display("FAIL flush_commit_grant got=%0b exp=0", alloc_grant); failures++;
    end
    step();
    // head = 3, tail = 33
    checks++;
    if (free_count !== fl_cnt_t'(30)) begin
      $display("FAIL flush_commit_count got=%0d exp=30", free_count); failures++;
    end
    for (int c = 0; c < 15; c++) begin
      alloc_req = 2'b11;
      #1;
      if (c == 0) begin
        checks++;
        if (alloc_preg[0] !== 6'd35 || alloc_preg[1] !== 6'd36) begin
          $display("FAIL flush_commit_head got {%0d,%0d} exp {36,35}",
                   alloc_preg[1], alloc_preg[0]); failures++;
        end
      end
      if (c == 14) begin
        checks++;
        if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd63 || alloc_preg[1] !== 6'd40) begin
          $display("FAIL flush_release_at_tail got grant=%0b {%0d,%0d} exp grant=1 {40,63}",
                   alloc_grant, alloc_preg[1], alloc_preg[0]); failures++;
        end
      end
      step();
    end
    checks++;
    if (free_count !== fl_cnt_t'(0)) begin
      $display("FAIL flush_commit_drain got=%0d exp=0", free_count); failures++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_req = 2'b11;
    step();
    alloc_req       = 2'b11;
    release_valid   = 2'b11;
    release_preg[0] = 6'd32;
    release_preg[1] = 6'd33;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_preg[0] !== 6'd34 || alloc_preg[1] !== 6'd35) begin
      $display("FAIL b2b_alloc got grant=%0b {%0d,%0d} exp grant=1 {35,34}",
               alloc_grant, alloc_preg[1], alloc_preg[0]); failures++;
    end
    step();
    checks++;
    if (free_count !== fl_cnt_t'(30)) begin
      $display("FAIL b2b_count got=%0d exp=30", free_count); failures++;
    end
    // Mid-operation reset overrides a same-cycle request.
    reset     = 1'b1;
    alloc_req = 2'b11;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (free_count !== fl_cnt_t'(32)) begin
      $display("FAIL midop_reset_count got=%0d exp=32", free_count); failures++;
    end
    alloc_req = 2'b01;
    #1;
    checks++;
    if (alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd0) begin
      $display("FAIL midop_reset_head got {%0d,%0d} exp {0,32}",
               alloc_preg[1], alloc_preg[0]); failures++;
    end
    step();
  endtask

  task automatic test_double_release();
    do_reset();
    alloc_req = 2'b11;
    step();
    release_valid   = 2'b01;
    release_preg[0] = 6'd3;
    step();
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL err_first_release got=%0b exp=0", err); failures++;
    end
    release_valid   = 2'b01;
    release_preg[0] = 6'd3;
    step();
    checks++;
    if (err !== EXP_ERR) begin
      $display("FAIL err_double_release got=%0b exp=%0b", err, EXP_ERR); failures++;
    end
    step();
    checks++;
    if (err !== EXP_ERR) begin
      $display("FAIL err_sticky got=%0b exp=%0b", err, EXP_ERR); failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_basic_alloc();
    test_drain();
    test_release_from_empty();
    test_flush_reclaim();
    test_flush_commit_release();
    test_back_to_back();
    test_double_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
